tap_addr_counter: RTL and testbench
===================================

// Module: tap_addr_counter
// PURPOSE
//  Parametrised modulo-N up/down counter with load, synchronous clear, ENP/ENT cascade enables and ripple-carry out.
//  Also has a single-sweep mode: a START pulse runs exactly one pass over 0..MODULUS-1, or the reverse, with BUSY/DONE handshake.
//  Generates FIR tap / coefficient-RAM addresses; replaces fixed 5-bit 74x163-style counters in the filter datapath.
// PARAMETERS
//  WIDTH    6   counter width in bits; must satisfy 2**WIDTH >= MODULUS (elaboration-time check, fatal on violation)
//  MODULUS  63  count range 0..MODULUS-1; MODULUS >= 2
// PORTS
//  CLK    in   1      rising-edge clock; the only clock
//  CLR_N  in   1      asynchronous, active-low reset
//  SCLR   in   1      synchronous clear, active-high
//  LD     in   1      synchronous parallel load of D
//  D      in   WIDTH  load value
//  ENP    in   1      count enable (parallel)
//  ENT    in   1      count enable (trickle); also gates RCO
//  UP     in   1      direction: 1 = up, 0 = down
//  MODE   in   1      0 = free-run, 1 = single sweep
//  START  in   1      sweep request; sampled only in IDLE with MODE=1
//  Q      out  WIDTH  count value (registered)
//  TC     out  1      terminal count, combinational: Q==MODULUS-1 when dir=up, Q==0 when dir=down
//  RCO    out  1      combinational: ENT & TC; for cascading
//  BUSY   out  1      registered; high while a sweep is in RUN
//  DONE   out  1      registered one-cycle pulse at end of sweep
// BEHAVIOUR
//  Reset: CLR_N=0 -> Q=0, state=IDLE, BUSY=0, DONE=0, dir=up, all immediately and asynchronously.
//  dir = UP in free-run; in sweep, dir = the UP value latched at START, held until the sweep ends.
//  Counting step (cnt = ENP & ENT):
//   - up: Q+1; MODULUS-1 wraps to 0
//   - down: Q-1; 0 wraps to MODULUS-1
//  Free-run (MODE=0, IDLE), priority per edge:
//   - SCLR: Q<=0
//   - else LD: Q<=D, or MODULUS-1 if D>=MODULUS (clamp)
//   - else cnt: step
//   - else hold
//  Sweep FSM, states IDLE and RUN:
//   - IDLE & MODE=1 & START & !SCLR -> RUN. Q<=0 if UP else MODULUS-1; dir<=UP; BUSY<=1.
//   - RUN, cnt & !TC: step.
//   - RUN, cnt & TC -> IDLE. Q holds at terminal (no wrap); BUSY<=0; DONE<=1 for exactly one cycle.
//   - RUN, !cnt: hold; the sweep stalls.
//   - RUN ignores LD, START and MODE.
//   - SCLR in RUN aborts: Q<=0, ->IDLE, BUSY<=0, no DONE.
//  Sweep length: with cnt held high, BUSY is high for exactly MODULUS cycles; DONE follows on the next cycle.
//  DONE and a new START can coincide: START is accepted in the DONE cycle because the state is already IDLE.
//  TC/RCO are valid in every state; RCO has no register latency.
//  Widths: all arithmetic is WIDTH bits; wrap is by explicit compare, never natural overflow (MODULUS need not be 2**WIDTH).
// STRUCTURE
//  Package tap_ctr_pkg:
//   - state typedef {IDLE, RUN}
//   - MODE_FREE=1'b0, MODE_SWEEP=1'b1
//  Sub-module mod_counter_core (WIDTH, MODULUS): Q register, step/wrap/clamp/load logic, TC.
//  Top level: FSM, dir latch, BUSY/DONE registers, RCO gating.
// TESTING (WIDTH=6, MODULUS=63 unless noted)
//  1. Free-run up, ENP=ENT=1 from Q=0: Q reaches 62, TC=RCO=1, then Q=0. ENT=0 at Q=62 -> RCO=0, Q holds.
//  2. Free-run down from 0: Q=62. LD with D=5 -> Q=5. LD with D=63 -> Q=62 (clamp). SCLR and LD together -> Q=0.
//  3. Sweep up: START at Q=17 -> Q=0, BUSY=1. BUSY stays high 63 cycles; DONE pulses one cycle; Q=62; BUSY=0.
//  4. Sweep down with ENP toggling every other cycle: 126 BUSY cycles. Flipping UP mid-sweep has no effect; ends at Q=0 with DONE.
//  5. SCLR at sweep cycle 10 -> Q=0, BUSY=0, no DONE. CLR_N low mid-sweep -> immediate reset values, no DONE.
//  6. MODULUS=10, WIDTH=4: up-wrap 9->0 and down-wrap 0->9. START asserted in the DONE cycle -> new sweep begins.

Source files
------------

// File: rtl/tap_ctr_pkg.sv
// Shared types for the tap address counter: sweep FSM states, mode encodings, core operations.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tap_ctr_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic MODE_FREE  = 1'b0;
    localparam logic MODE_SWEEP = 1'b1;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Operation the control logic asks the counter core to perform this edge.
    typedef enum logic [2:0] {
        OP_HOLD  = 3'd0,
        OP_CLEAR = 3'd1,
        OP_LOAD  = 3'd2,
        OP_INIT  = 3'd3,
        OP_STEP  = 3'd4
    } ctr_op_t;

endpackage

// File: rtl/mod_counter_core.sv
// Modulo-MODULUS count register with clear, clamped load, sweep-start preset and wrapping step; TC decode.
// Latency: Q updates one CLK after op; TC is combinational from Q and dir.
// Backpressure: none; the caller stalls the count by issuing OP_HOLD.
module mod_counter_core
    import tap_ctr_pkg::*;
#(
    parameter int WIDTH   = 6,
    parameter int MODULUS = 63
) (
    input  logic             CLK,
    input  logic             CLR_N,
    input  ctr_op_t          op,
    input  logic             dir,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] Q_MIN = '0;

    // The count range must fit in the register and hold at least two values.
    if ((MODULUS < 2) || (WIDTH < 1) || ((64'd1 << WIDTH) < 64'(MODULUS))) begin : g_bad_params
        $fatal(1, "mod_counter_core: WIDTH=%0d cannot hold MODULUS=%0d (need MODULUS>=2, 2**WIDTH>=MODULUS)",
               WIDTH, MODULUS);
    end

    logic [WIDTH-1:0] q_inc;
    logic [WIDTH-1:0] q_dec;
    logic [WIDTH-1:0] d_clamped;
    logic [WIDTH-1:0] q_next;

    // Wrap by explicit compare so non-power-of-two moduli never rely on overflow.
    always_comb begin
        q_inc     = (q == Q_MAX) ? Q_MIN : q + WIDTH'(1);
        q_dec     = (q == Q_MIN) ? Q_MAX : q - WIDTH'(1);
        d_clamped = (d > Q_MAX) ? Q_MAX : d;
        q_next    = q;
        case (op)
            OP_CLEAR: q_next = Q_MIN;
            OP_LOAD:  q_next = d_clamped;
            OP_INIT:  q_next = (dir == DIR_UP) ? Q_MIN : Q_MAX;
            OP_STEP:  q_next = (dir == DIR_UP) ? q_inc : q_dec;
            default:  q_next = q;
        endcase
    end

    // Count register.
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            q <= Q_MIN;
        end else begin
            q <= q_next;
        end
    end

    // Terminal count depends on the direction currently in force.
    always_comb begin
        tc = (dir == DIR_UP) ? (q == Q_MAX) : (q == Q_MIN);
    end

endmodule

// File: rtl/tap_addr_counter.sv
// FIR tap address counter: free-running modulo up/down counter or single-sweep generator with BUSY/DONE.
// Latency: Q/BUSY/DONE one CLK after the controlling inputs; TC/RCO combinational.
// Backpressure: ENP&ENT low holds the count (stalls a sweep); no other flow control.
module tap_addr_counter
    import tap_ctr_pkg::*;
#(
    parameter int WIDTH   = 6,
    parameter int MODULUS = 63
) (
    input  logic             CLK,
    input  logic             CLR_N,
    input  logic             SCLR,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    input  logic             ENP,
    input  logic             ENT,
    input  logic             UP,
    input  logic             MODE,
    input  logic             START,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             RCO,
    output logic             BUSY,
    output logic             DONE
);

    state_t  state_q;
    state_t  state_d;
    logic    dir_q;
    logic    dir_d;
    logic    busy_q;
    logic    busy_d;
    logic    done_q;
    logic    done_d;
    logic    dir_eff;
    logic    cnt;
    ctr_op_t op;

    // A sweep runs in the direction captured at START; otherwise UP drives directly.
    always_comb begin
        dir_eff = (state_q == RUN) ? dir_q : UP;
        cnt     = ENP & ENT;
    end

    mod_counter_core #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_core (
        .CLK   (CLK),
        .CLR_N (CLR_N),
        .op    (op),
        .dir   (dir_eff),
        .d     (D),
        .q     (Q),
        .tc    (TC)
    );

    // Cascade output needs no register stage.
    always_comb begin
        RCO = ENT & TC;
    end

    // Next-state and counter-op decode. In IDLE with MODE=SWEEP the counter
    // only clears or arms a sweep; load and free counting need MODE=FREE.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        op      = OP_HOLD;
        case (state_q)
            IDLE: begin
                if (SCLR) begin
                    op = OP_CLEAR;
                end else if (MODE == MODE_SWEEP) begin
                    if (START) begin
                        op      = OP_INIT;
                        state_d = RUN;
                        dir_d   = UP;
                        busy_d  = 1'b1;
                    end
                end else if (LD) begin
                    op = OP_LOAD;
                end else if (cnt) begin
                    op = OP_STEP;
                end
            end
            RUN: begin
                if (SCLR) begin
                    // Abort: clear and drop out without signalling completion.
                    op      = OP_CLEAR;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (cnt) begin
                    if (TC) begin
                        // Last address already presented; hold it rather than wrap.
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        op = OP_STEP;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // FSM, sweep-direction latch and handshake registers.
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state_q <= IDLE;
            dir_q   <= DIR_UP;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        BUSY = busy_q;
        DONE = done_q;
    end

endmodule

// File: tb/tb_tap_addr_counter.sv
// Bench for tap_addr_counter: 6-bit/63 and 4-bit/10 instances against a behavioural model.
// Latency: outputs compared at every falling edge; inputs change right after each compare.
// Backpressure: n/a.
module tb_tap_addr_counter;

    logic       CLK = 1'b0;
    logic       CLR_N = 1'b1;

    logic       a_sclr = 0, a_ld = 0, a_enp = 0, a_ent = 0, a_up = 1, a_mode = 0, a_start = 0;
    logic [5:0] a_d = '0;
    logic [5:0] a_q;
    logic       a_tc, a_rco, a_busy, a_done;

    logic       b_sclr = 0, b_ld = 0, b_enp = 0, b_ent = 0, b_up = 1, b_mode = 0, b_start = 0;
    logic [3:0] b_d = '0;
    logic [3:0] b_q;
    logic       b_tc, b_rco, b_busy, b_done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    tap_addr_counter #(.WIDTH(6), .MODULUS(63)) u_dut_a (
        .CLK(CLK), .CLR_N(CLR_N), .SCLR(a_sclr), .LD(a_ld), .D(a_d), .ENP(a_enp), .ENT(a_ent),
        .UP(a_up), .MODE(a_mode), .START(a_start), .Q(a_q), .TC(a_tc), .RCO(a_rco),
        .BUSY(a_busy), .DONE(a_done)
    );

    tap_addr_counter #(.WIDTH(4), .MODULUS(10)) u_dut_b (
        .CLK(CLK), .CLR_N(CLR_N), .SCLR(b_sclr), .LD(b_ld), .D(b_d), .ENP(b_enp), .ENT(b_ent),
        .UP(b_up), .MODE(b_mode), .START(b_start), .Q(b_q), .TC(b_tc), .RCO(b_rco),
        .BUSY(b_busy), .DONE(b_done)
    );

    // ---------------- behavioural model ----------------
    typedef struct {
        int q;
        bit run;
        bit sdir;
        bit done;
    } mst_t;

    mst_t ma, mb;

    function automatic mst_t m_reset();
        mst_t r;
        r.q = 0; r.run = 1'b0; r.sdir = 1'b1; r.done = 1'b0;
        return r;
    endfunction

    function automatic bit m_tc(input mst_t s, input int m, input bit up);
        bit dr = s.run ? s.sdir : up;
        return dr ? (s.q == m - 1) : (s.q == 0);
    endfunction

    function automatic mst_t m_next(input mst_t s, input int m, input bit sclr, input bit ld,
                                    input int d, input bit enp, input bit ent, input bit up,
                                    input bit mode, input bit start);
        mst_t n = s;
        bit dr = s.run ? s.sdir : up;
        bit at_end = m_tc(s, m, up);
        int stepped = dr ? (s.q + 1) % m : (s.q + m - 1) % m;
        n.done = 1'b0;
        if (sclr) begin
            n.q = 0;
            n.run = 1'b0;
        end else if (s.run) begin
            if (enp && ent) begin
                if (at_end) begin
                    n.run = 1'b0;
                    n.done = 1'b1;
                end else begin
                    n.q = stepped;
                end
            end
        end else if (mode) begin
            if (start) begin
                n.run = 1'b1;
                n.sdir = up;
                n.q = up ? 0 : m - 1;
            end
        end else if (ld) begin
            n.q = (d >= m) ? m - 1 : d;
        end else if (enp && ent) begin
            n.q = stepped;
        end
        return n;
    endfunction

    always @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            ma <= m_reset();
            mb <= m_reset();
        end else begin
            ma <= m_next(ma, 63, a_sclr, a_ld, int'(a_d), a_enp, a_ent, a_up, a_mode, a_start);
            mb <= m_next(mb, 10, b_sclr, b_ld, int'(b_d), b_enp, b_ent, b_up, b_mode, b_start);
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        bit ta, tb;
        ta = m_tc(ma, 63, a_up);
        tb = m_tc(mb, 10, b_up);
        check("a_q", 32'(a_q), ma.q);
        check("a_tc", 32'(a_tc), 32'(ta));
        check("a_rco", 32'(a_rco), 32'(a_ent & ta));
        check("a_busy", 32'(a_busy), 32'(ma.run));
        check("a_done", 32'(a_done), 32'(ma.done));
        check("b_q", 32'(b_q), mb.q);
        check("b_tc", 32'(b_tc), 32'(tb));
        check("b_rco", 32'(b_rco), 32'(b_ent & tb));
        check("b_busy", 32'(b_busy), 32'(mb.run));
        check("b_done", 32'(b_done), 32'(mb.done));
    endtask

    task automatic tick();
        @(negedge CLK);
        compare_all();
    endtask

    // Runs instance A's sweep from the cycle after START until BUSY drops (bounded).
    task automatic sweep_a(input bit toggle, input int flip_at, input int sclr_at,
                           output int nbusy, output bit saw_done);
        nbusy = 1;
        saw_done = 1'b0;
        for (int k = 0; k < 400; k++) begin
            a_start = (k == 30);
            a_ld = (k == 20);
            a_d = 6'd5;
            a_mode = (k != 40);
            a_enp = toggle ? k[0] : 1'b1;
            if (k == flip_at) a_up = ~a_up;
            a_sclr = (k == sclr_at);
            tick();
            if (!a_busy) begin
                saw_done = a_done;
                break;
            end
            nbusy++;
        end
        a_start = 1'b0;
        a_ld = 1'b0;
        a_sclr = 1'b0;
        a_mode = 1'b1;
    endtask

    task automatic sweep_b(output int nbusy, output bit saw_done);
        nbusy = 1;
        saw_done = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (!b_busy) begin
                saw_done = b_done;
                break;
            end
            nbusy++;
        end
    endtask

    initial begin
        int nb;
        bit sd;
        #1 CLR_N = 1'b0;
        tick();
        check("rst_a_q", 32'(a_q), 0);
        check("rst_a_busy", 32'(a_busy), 0);
        check("rst_a_done", 32'(a_done), 0);
        CLR_N = 1'b1;
        tick();

        // 1: free-run up, wrap, RCO gating by ENT
        a_enp = 1; a_ent = 1; a_up = 1;
        for (int i = 0; i < 62; i++) tick();
        check("t1_q62", 32'(a_q), 62);
        check("t1_tc", 32'(a_tc), 1);
        check("t1_rco", 32'(a_rco), 1);
        tick();
        check("t1_wrap0", 32'(a_q), 0);
        for (int i = 0; i < 62; i++) tick();
        a_ent = 0;
        #1;
        check("t1_rco_ent0", 32'(a_rco), 0);
        check("t1_tc_ent0", 32'(a_tc), 1);
        tick();
        check("t1_hold", 32'(a_q), 62);

        // 2: down wrap, load, clamp, SCLR priority
        a_sclr = 1; tick();
        check("t2_sclr", 32'(a_q), 0);
        a_sclr = 0; a_ent = 1; a_up = 0; tick();
        check("t2_down_wrap", 32'(a_q), 62);
        a_enp = 0; a_ld = 1; a_d = 6'd5; tick();
        check("t2_ld5", 32'(a_q), 5);
        a_d = 6'd63; tick();
        check("t2_clamp", 32'(a_q), 62);
        a_sclr = 1; a_d = 6'd5; tick();
        check("t2_sclr_over_ld", 32'(a_q), 0);
        a_sclr = 0; a_ld = 0;

        // 3: up sweep started from Q=17
        a_ld = 1; a_d = 6'd17; tick();
        check("t3_ld17", 32'(a_q), 17);
        a_ld = 0; a_mode = 1; a_up = 1; a_enp = 1; a_start = 1; tick();
        check("t3_start_q", 32'(a_q), 0);
        check("t3_start_busy", 32'(a_busy), 1);
        a_start = 0;
        sweep_a(1'b0, -1, -1, nb, sd);
        check("t3_busy_cycles", nb, 63);
        check("t3_done", 32'(sd), 1);
        check("t3_end_q", 32'(a_q), 62);
        tick();
        check("t3_done_1cyc", 32'(a_done), 0);

        // 4: down sweep with ENP toggling, UP flipped mid-sweep
        a_up = 0; a_start = 1; tick();
        check("t4_start_q", 32'(a_q), 62);
        a_start = 0;
        sweep_a(1'b1, 50, -1, nb, sd);
        check("t4_busy_cycles", nb, 126);
        check("t4_done", 32'(sd), 1);
        check("t4_end_q", 32'(a_q), 0);
        a_enp = 1;
        tick();
        check("t4_done_1cyc", 32'(a_done), 0);

        // 5: SCLR abort, then async reset mid-sweep
        a_up = 1; a_start = 1; tick();
        a_start = 0;
        sweep_a(1'b0, -1, 9, nb, sd);
        check("t5_abort_cycles", nb, 10);
        check("t5_abort_nodone", 32'(sd), 0);
        check("t5_abort_q", 32'(a_q), 0);
        tick();
        check("t5_abort_nodone2", 32'(a_done), 0);
        a_start = 1; tick();
        a_start = 0;
        for (int i = 0; i < 5; i++) tick();
        CLR_N = 1'b0;
        #1;
        check("t5_arst_q", 32'(a_q), 0);
        check("t5_arst_busy", 32'(a_busy), 0);
        check("t5_arst_done", 32'(a_done), 0);
        tick();
        CLR_N = 1'b1;
        a_mode = 0;
        tick();
        check("t5_arst_nodone", 32'(a_done), 0);

        // 6: MODULUS=10 wraps and back-to-back sweeps
        b_enp = 1; b_ent = 1; b_up = 1; b_mode = 0;
        for (int i = 0; i < 9; i++) tick();
        check("t6_q9", 32'(b_q), 9);
        tick();
        check("t6_up_wrap", 32'(b_q), 0);
        b_up = 0; tick();
        check("t6_down_wrap", 32'(b_q), 9);
        b_mode = 1; b_up = 1; b_start = 1; tick();
        check("t6_start_q", 32'(b_q), 0);
        b_start = 0;
        sweep_b(nb, sd);
        check("t6_busy_cycles", nb, 10);
        check("t6_done", 32'(sd), 1);
        b_start = 1; tick();
        check("t6_restart_busy", 32'(b_busy), 1);
        check("t6_restart_q", 32'(b_q), 0);
        b_start = 0;
        sweep_b(nb, sd);
        check("t6_busy_cycles2", nb, 10);
        check("t6_done2", 32'(sd), 1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
